// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hard-wired CPU control sequencer:
// state encoding, opcode values and instruction field positions.
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;
    localparam int REG_W = 4;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MD,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU;
            OP_MUL, OP_DIV:                  return CLS_MD;
            OP_NOP:                          return CLS_NOP;
            OP_HALT:                         return CLS_HALT;
            default:                         return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Turns a register-number field into a one-hot register strobe vector;
// the vector is all zero while the enable is low.
module reg_field_decoder #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0]      field,
    input  logic                  en,
    output logic [(1<<REG_W)-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[field] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control FSM for CPU_Datapath: fetch in T0-T2, then decode and
// execute ALU, mul/div, nop and halt instructions in T3-T6.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             ZLOout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Yout,
    output logic             Loin,
    output logic             ZHIout,
    output logic             HIin,
    output logic [15:0]      Rin_vec,
    output logic [15:0]      Rout_vec,
    output logic [OPC_W-1:0] ALUSelection,
    output logic             run,
    output logic             illegal_op
);

    state_e             state_q, state_d;
    op_class_e          op_class;
    logic [OPC_W-1:0]   opc;
    logic [REG_W-1:0]   ra, rb, rc, rout_sel;
    logic               rin_en, rout_en;
    logic               ir_low_unused;

    assign opc           = ir[OPC_MSB:OPC_LSB];
    assign ra            = ir[RA_MSB:RA_LSB];
    assign rb            = ir[RB_MSB:RB_LSB];
    assign rc            = ir[RC_MSB:RC_LSB];
    assign ir_low_unused = ^ir[RC_LSB-1:0];
    assign op_class      = classify(opc);

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output is defaulted first so no path through the case infers a latch.
        state_d      = state_q;
        PCout        = 1'b0;
        MARin        = 1'b0;
        IncPC        = 1'b0;
        Zin          = 1'b0;
        ZLOout       = 1'b0;
        PCin         = 1'b0;
        Read         = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        Yout         = 1'b0;
        Loin         = 1'b0;
        ZHIout       = 1'b0;
        HIin         = 1'b0;
        ALUSelection = '0;
        illegal_op   = 1'b0;
        rin_en       = 1'b0;
        rout_en      = 1'b0;
        rout_sel     = rb;

        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                {PCout, MARin, IncPC, Zin} = 4'b1111;
                state_d = S_T1;
            end
            S_T1: begin
                {Read, MDRin, ZLOout} = 3'b111;
                if (mem_ready) begin
                    PCin    = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                {MDRout, IRin} = 2'b11;
                state_d = S_T3;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU: begin
                        {rout_en, Yin} = 2'b11;
                        state_d = S_T4;
                    end
                    CLS_MD: begin
                        {rout_en, Yin} = 2'b11;
                        rout_sel = ra;
                        state_d  = S_T4;
                    end
                    CLS_NOP:  state_d = S_T0;
                    CLS_HALT: state_d = S_HALT;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_T0;
                    end
                endcase
            end
            S_T4: begin
                // Second ALU operand: Rc for register ALU ops, Rb for mul/div.
                state_d = S_T0;
                if (op_class == CLS_ALU || op_class == CLS_MD) begin
                    {rout_en, Yout, Zin} = 3'b111;
                    rout_sel     = (op_class == CLS_ALU) ? rc : rb;
                    ALUSelection = opc;
                    state_d      = S_T5;
                end
            end
            S_T5: begin
                state_d = S_T0;
                if (op_class == CLS_ALU) begin
                    {ZLOout, rin_en} = 2'b11;
                end else if (op_class == CLS_MD) begin
                    {ZLOout, Loin} = 2'b11;
                    state_d = S_T6;
                end
            end
            S_T6: begin
                {ZHIout, HIin} = 2'b11;
                state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign run = (state_q != S_IDLE) && (state_q != S_HALT);

    reg_field_decoder #(.REG_W(REG_W)) u_rin_dec (
        .field  (ra),
        .en     (rin_en),
        .onehot (Rin_vec)
    );

    reg_field_decoder #(.REG_W(REG_W)) u_rout_dec (
        .field  (rout_sel),
        .en     (rout_en),
        .onehot (Rout_vec)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the per-cycle
// expected control word from an instruction-level model; a monitor compares.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, start, mem_ready;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin;
    logic        MDRout, IRin, Yin, Yout, Loin, ZHIout, HIin;
    logic [15:0] Rin_vec, Rout_vec;
    logic [4:0]  ALUSelection;
    logic        run, illegal_op;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .ir           (ir),
        .mem_ready    (mem_ready),
        .PCout        (PCout),
        .MARin        (MARin),
        .IncPC        (IncPC),
        .Zin          (Zin),
        .ZLOout       (ZLOout),
        .PCin         (PCin),
        .Read         (Read),
        .MDRin        (MDRin),
        .MDRout       (MDRout),
        .IRin         (IRin),
        .Yin          (Yin),
        .Yout         (Yout),
        .Loin         (Loin),
        .ZHIout       (ZHIout),
        .HIin         (HIin),
        .Rin_vec      (Rin_vec),
        .Rout_vec     (Rout_vec),
        .ALUSelection (ALUSelection),
        .run          (run),
        .illegal_op   (illegal_op)
    );

    typedef struct packed {
        logic [14:0] stb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run;
        logic        ill;
    } ovec_t;

    localparam logic [14:0] B_PCOUT  = 15'h0001;
    localparam logic [14:0] B_MARIN  = 15'h0002;
    localparam logic [14:0] B_INCPC  = 15'h0004;
    localparam logic [14:0] B_ZIN    = 15'h0008;
    localparam logic [14:0] B_ZLO    = 15'h0010;
    localparam logic [14:0] B_PCIN   = 15'h0020;
    localparam logic [14:0] B_READ   = 15'h0040;
    localparam logic [14:0] B_MDRIN  = 15'h0080;
    localparam logic [14:0] B_MDROUT = 15'h0100;
    localparam logic [14:0] B_IRIN   = 15'h0200;
    localparam logic [14:0] B_YIN    = 15'h0400;
    localparam logic [14:0] B_YOUT   = 15'h0800;
    localparam logic [14:0] B_LOIN   = 15'h1000;
    localparam logic [14:0] B_ZHI    = 15'h2000;
    localparam logic [14:0] B_HIIN   = 15'h4000;

    ovec_t exp_q[$];
    ovec_t seq[$];
    int    checks = 0;
    int    errors = 0;

    function automatic ovec_t cur();
        ovec_t v;
        v.stb  = {HIin, ZHIout, Loin, Yout, Yin, IRin, MDRout, MDRin,
                  Read, PCin, ZLOout, Zin, IncPC, MARin, PCout};
        v.rin  = Rin_vec;
        v.rout = Rout_vec;
        v.alu  = ALUSelection;
        v.run  = run;
        v.ill  = illegal_op;
        return v;
    endfunction

    task automatic check(input string name, input ovec_t got, input ovec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got stb=%h rin=%h rout=%h alu=%h run=%b ill=%b | want stb=%h rin=%h rout=%h alu=%h run=%b ill=%b",
                     name, $time, got.stb, got.rin, got.rout, got.alu, got.run, got.ill,
                     exp.stb, exp.rin, exp.rout, exp.alu, exp.run, exp.ill);
        end
    endtask

    function automatic ovec_t mk(input logic [14:0] stb, input logic [15:0] rin,
                                 input logic [15:0] rout, input logic [4:0] alu,
                                 input logic ill);
        ovec_t v;
        v.stb  = stb;
        v.rin  = rin;
        v.rout = rout;
        v.alu  = alu;
        v.run  = 1'b1;
        v.ill  = ill;
        return v;
    endfunction

    // Instruction-level reference: the control word for each cycle of one instruction.
    function automatic void build(input logic [31:0] insn, input int waits);
        logic [4:0]  opc = insn[31:27];
        logic [3:0]  ra  = insn[26:23];
        logic [3:0]  rb  = insn[22:19];
        logic [3:0]  rc  = insn[18:15];
        bit          is_alu = (opc >= 5'd3) && (opc <= 5'd11);
        bit          is_md  = (opc == 5'd15) || (opc == 5'd16);
        seq.delete();
        seq.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 16'h0, 16'h0, 5'd0, 1'b0));
        for (int w = 0; w < waits; w++)
            seq.push_back(mk(B_READ | B_MDRIN | B_ZLO, 16'h0, 16'h0, 5'd0, 1'b0));
        seq.push_back(mk(B_READ | B_MDRIN | B_ZLO | B_PCIN, 16'h0, 16'h0, 5'd0, 1'b0));
        seq.push_back(mk(B_MDROUT | B_IRIN, 16'h0, 16'h0, 5'd0, 1'b0));
        if (is_alu) begin
            seq.push_back(mk(B_YIN, 16'h0, 16'h1 << rb, 5'd0, 1'b0));
            seq.push_back(mk(B_YOUT | B_ZIN, 16'h0, 16'h1 << rc, opc, 1'b0));
            seq.push_back(mk(B_ZLO, 16'h1 << ra, 16'h0, 5'd0, 1'b0));
        end else if (is_md) begin
            seq.push_back(mk(B_YIN, 16'h0, 16'h1 << ra, 5'd0, 1'b0));
            seq.push_back(mk(B_YOUT | B_ZIN, 16'h0, 16'h1 << rb, opc, 1'b0));
            seq.push_back(mk(B_ZLO | B_LOIN, 16'h0, 16'h0, 5'd0, 1'b0));
            seq.push_back(mk(B_ZHI | B_HIIN, 16'h0, 16'h0, 5'd0, 1'b0));
        end else if (opc == 5'd26 || opc == 5'd27) begin
            seq.push_back(mk(15'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        end else begin
            seq.push_back(mk(15'h0, 16'h0, 16'h0, 5'd0, 1'b1));
        end
    endfunction

    // One cycle where the sequencer is expected to be inactive (IDLE, HALT or held in clr).
    task automatic idle_cyc(input logic st);
        start     = st;
        mem_ready = 1'($urandom_range(0, 1));
        ir        = $urandom;
        exp_q.push_back('0);
        @(posedge clk); #1;
    endtask

    // Drives one instruction; ir is garbage until T3, mem_ready is random outside T1.
    task automatic run_instr(input logic [31:0] insn, input int waits, input bit abort_t4);
        build(insn, waits);
        for (int k = 0; k < seq.size(); k++) begin
            start = 1'($urandom_range(0, 1));
            if (k >= 1 && k <= waits + 1) mem_ready = (k == waits + 1);
            else                          mem_ready = 1'($urandom_range(0, 1));
            ir = (k >= waits + 3) ? insn : $urandom;
            if (abort_t4 && k == waits + 4) begin
                exp_q.push_back('0);
                #1 check("t4_before_clr", cur(), seq[k]);
                #1 clr = 1'b1;
                #1 check("clr_async_drop", cur(), '0);
                @(posedge clk); #1;
                start = 1'b0;
                exp_q.push_back('0);
                @(posedge clk); #1;
                clr = 1'b0;
                break;
            end
            exp_q.push_back(seq[k]);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0] ops [18] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                 5'd15, 5'd16, 5'd26, 5'd0, 5'd1, 5'd2, 5'd12, 5'd20, 5'd31};
        logic [31:0] r = $urandom;
        return {ops[$urandom_range(0, 17)], r[26:0]};
    endfunction

    initial begin
        ovec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", cur(), e);
            end else if (run) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run @%0t: run=%b with nothing expected", $time, run);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
        @(posedge clk); #1;
        idle_cyc(1'b1);
        idle_cyc(1'b0);
        clr = 1'b0;
        idle_cyc(1'b0);
        idle_cyc(1'b0);
        idle_cyc(1'b1);

        run_instr(32'h30918000, 0, 1'b0);   // or  R1,R2,R3
        run_instr(32'h7A280000, 0, 1'b0);   // mul R4,R5
        run_instr(32'h18918000, 3, 1'b0);   // add with 3-cycle memory wait
        run_instr(32'hD0000000, 0, 1'b0);   // nop
        run_instr(32'hF8000000, 0, 1'b0);   // illegal
        run_instr(32'h8200_0000, 2, 1'b0);  // div R4,R0 with Ra=R4
        run_instr(32'h48000000, 0, 1'b0);   // shl writing back to R0
        for (int i = 0; i < 40; i++)
            run_instr(rand_insn(), $urandom_range(0, 3), 1'b0);

        run_instr(32'h20918000, 1, 1'b1);   // sub, cleared in T4
        idle_cyc(1'b0);
        idle_cyc(1'b1);
        run_instr(32'h58918000, 0, 1'b0);   // rol after restart
        run_instr(32'hD8000000, 0, 1'b0);   // halt
        repeat (4) idle_cyc(1'b1);          // start is ignored in HALT
        clr = 1'b1;
        idle_cyc(1'b0);
        clr = 1'b0;
        idle_cyc(1'b0);
        idle_cyc(1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never compared, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
